// File: rtl/riscv_pkg.sv
// Shared definitions for the multi-cycle RV32 control sequencer:
// opcode constants, FSM state encodings, instruction class enum,
// datapath select encodings and the opcode classifier.
package riscv_pkg;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } state_e;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I_ALU  = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_JALR   = 3'd6,
        CLS_LUI    = 3'd7
    } instr_class_e;

    // PC source select
    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;  // pc + 4
    localparam logic [1:0] PC_SRC_TARGET = 2'b01;  // branch / jal target
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;  // rs1 + imm

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;
    localparam logic [1:0] WB_IMM = 2'b11;

    // ALU operation select
    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_CMP     = 2'b01;
    localparam logic [1:0] ALU_R_FUNCT = 2'b10;
    localparam logic [1:0] ALU_I_FUNCT = 2'b11;

    typedef struct packed {
        logic         valid;
        instr_class_e cls;
    } decode_t;

    // Maps the IR opcode field to an instruction class; valid=0 flags an
    // opcode this sequencer does not implement.
    function automatic decode_t decode_opcode(input logic [6:0] op);
        decode_t d;
        d.valid = 1'b1;
        d.cls   = CLS_R;
        case (op)
            OP_R_TYPE: d.cls = CLS_R;
            OP_I_ALU:  d.cls = CLS_I_ALU;
            OP_LOAD:   d.cls = CLS_LOAD;
            OP_STORE:  d.cls = CLS_STORE;
            OP_BRANCH: d.cls = CLS_BRANCH;
            OP_JAL:    d.cls = CLS_JAL;
            OP_JALR:   d.cls = CLS_JALR;
            OP_LUI:    d.cls = CLS_LUI;
            default:   d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-cycle counter shared by the instruction-fetch and data-memory
// handshakes. Counts cycles spent waiting for a ready and flags when the
// count reaches the configured limit.
//   clk      in  1  clock, rising edge
//   reset    in  1  asynchronous, active-high
//   clear    in  1  restart the count (state entry)
//   count_en in  1  request outstanding and ready low this cycle
//   limit    in  W  wait limit; 0 disables expiry
//   expired  out 1  count has reached a non-zero limit
module mem_wait_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         count_en,
    input  logic [W-1:0] limit,
    output logic         expired
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Saturates at the limit so a long stall never wraps back below it.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en && (count_q != limit)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (limit != '0) && (count_q == limit);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for an RV32 datapath with a single shared ALU,
// register file and memory port. Steps each instruction through
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, owns the memory handshakes,
// a bus timeout, the illegal-opcode trap and the retired-instruction count.
//   clk, reset         clock and asynchronous active-high reset
//   opcode             IR[6:0], sampled in DECODE
//   branch_taken       ALU compare result, used in EXECUTE
//   imem_ready         instruction memory ack
//   dmem_ready         data memory ack
//   imem_req, ir_load  fetch request / IR capture strobe
//   pc_load, pc_src    PC update strobe and source select
//   dmem_req, dmem_we  data memory request / write
//   alu_control        ALU op select; imm_enable selects immediate operand B
//   reg_write_enable   regfile write strobe; wb_sel writeback source
//   illegal_instr      sticky unknown-opcode trap flag
//   bus_error          sticky memory timeout trap flag
//   state_o            current state (debug)
//   instret_count      retired instructions, wrapping
module multicycle_sequencer
    import riscv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int          CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_load,
    output logic             pc_load,
    output logic [1:0]       pc_src,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [1:0]       alu_control,
    output logic             imm_enable,
    output logic             reg_write_enable,
    output logic [1:0]       wb_sel,
    output logic             illegal_instr,
    output logic             bus_error,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret_count
);

    localparam int TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    state_e             state_q, state_d;
    instr_class_e       class_q, class_d;
    logic               illegal_q, illegal_d;
    logic               bus_err_q, bus_err_d;
    logic [CNT_W-1:0]   instret_q, instret_d;

    decode_t            dec;
    logic               tmr_clear;
    logic               tmr_count_en;
    logic               tmr_expired;

    assign dec = decode_opcode(opcode);

    // Any state change restarts the wait count, so both FETCH and MEMORY
    // start from zero no matter which state they were entered from.
    assign tmr_clear    = (state_d != state_q);
    assign tmr_count_en = ((state_q == ST_FETCH)  && !imem_ready) ||
                          ((state_q == ST_MEMORY) && !dmem_ready);

    mem_wait_timer #(
        .W(TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .count_en (tmr_count_en),
        .limit    (TMR_W'(TIMEOUT_CYCLES)),
        .expired  (tmr_expired)
    );

    // State register and control flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            class_q   <= CLS_R;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
            instret_q <= instret_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        class_d   = class_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                // A ready arriving on the limit cycle still completes the fetch.
                if (imem_ready) begin
                    state_d = ST_DECODE;
                end else if (tmr_expired) begin
                    state_d   = ST_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (dec.valid) begin
                    class_d = dec.cls;
                    state_d = ST_EXECUTE;
                end else begin
                    state_d   = ST_TRAP;
                    illegal_d = 1'b1;
                end
            end
            ST_EXECUTE: begin
                case (class_q)
                    CLS_BRANCH:          state_d = ST_FETCH;
                    CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
                    default:             state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                if (dmem_ready) begin
                    state_d = (class_q == CLS_STORE) ? ST_FETCH : ST_WRITEBACK;
                end else if (tmr_expired) begin
                    state_d   = ST_TRAP;
                    bus_err_d = 1'b1;
                end
            end
            ST_WRITEBACK: state_d = ST_FETCH;
            ST_TRAP:      state_d = ST_TRAP;
            default:      state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        imem_req         = 1'b0;
        ir_load          = 1'b0;
        pc_load          = 1'b0;
        pc_src           = PC_SRC_SEQ;
        dmem_req         = 1'b0;
        dmem_we          = 1'b0;
        alu_control      = ALU_ADD;
        imm_enable       = 1'b0;
        reg_write_enable = 1'b0;
        wb_sel           = WB_ALU;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_load  = imem_ready;
            end
            ST_EXECUTE: begin
                case (class_q)
                    CLS_R: alu_control = ALU_R_FUNCT;
                    CLS_I_ALU: begin
                        alu_control = ALU_I_FUNCT;
                        imm_enable  = 1'b1;
                    end
                    CLS_BRANCH: begin
                        alu_control = ALU_CMP;
                        pc_load     = 1'b1;
                        pc_src      = branch_taken ? PC_SRC_TARGET : PC_SRC_SEQ;
                    end
                    // Address / target / immediate pass-through: add with imm.
                    default: begin
                        alu_control = ALU_ADD;
                        imm_enable  = 1'b1;
                    end
                endcase
            end
            ST_MEMORY: begin
                dmem_req   = 1'b1;
                dmem_we    = (class_q == CLS_STORE);
                imm_enable = 1'b1;
                pc_load    = dmem_ready && (class_q == CLS_STORE);
            end
            ST_WRITEBACK: begin
                reg_write_enable = 1'b1;
                pc_load          = 1'b1;
                case (class_q)
                    CLS_LOAD: wb_sel = WB_MEM;
                    CLS_JAL: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_SRC_TARGET;
                    end
                    CLS_JALR: begin
                        wb_sel = WB_PC4;
                        pc_src = PC_SRC_JALR;
                    end
                    CLS_LUI: wb_sel = WB_IMM;
                    default: wb_sel = WB_ALU;
                endcase
            end
            default: ;
        endcase
    end

    // Every pc_load marks the retirement of the current instruction.
    always_comb begin
        instret_d = pc_load ? (instret_q + CNT_W'(1)) : instret_q;
    end

    assign illegal_instr = illegal_q;
    assign bus_error     = bus_err_q;
    assign state_o       = state_q;
    assign instret_count = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: each instruction is expanded into its expected per-cycle
// trace from the phase rules (fetch waits, decode, execute, memory waits,
// writeback), which also yields the ready/branch stimulus. A single compare
// process checks every cycle; literal checks pin key points of the model.
module tb_multicycle_sequencer;

    localparam int TMO   = 4;
    localparam int CNT_W = 4;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam int K_WB = 0, K_LOAD = 1, K_STORE = 2, K_BR = 3;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [6:0]       opcode = '0;
    logic             branch_taken = 1'b0;
    logic             imem_ready = 1'b0;
    logic             dmem_ready = 1'b0;
    logic             imem_req, ir_load, pc_load, dmem_req, dmem_we;
    logic             imm_enable, reg_write_enable, illegal_instr, bus_error;
    logic [1:0]       pc_src, alu_control, wb_sel;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] instret_count;

    multicycle_sequencer #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_load(ir_load), .pc_load(pc_load), .pc_src(pc_src),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .alu_control(alu_control),
        .imm_enable(imm_enable), .reg_write_enable(reg_write_enable), .wb_sel(wb_sel),
        .illegal_instr(illegal_instr), .bus_error(bus_error), .state_o(state_o),
        .instret_count(instret_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             rst;
        logic [6:0]       opcode;
        logic             br;
        logic             iready;
        logic             dready;
        logic [2:0]       st;
        logic             imem_req;
        logic             ir_load;
        logic             pc_load;
        logic [1:0]       pc_src;
        logic             dmem_req;
        logic             dmem_we;
        logic [1:0]       alu;
        logic             imm;
        logic             rwe;
        logic [1:0]       wb;
        logic             ill;
        logic             berr;
        logic [CNT_W-1:0] instret;
    } cyc_t;

    typedef struct packed {
        logic       valid;
        int         kind;
        logic [1:0] alu;
        logic       imm;
        logic [1:0] wb;
        logic [1:0] wbpc;
    } info_t;

    cyc_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    logic [CNT_W-1:0] m_instret = '0;
    logic             m_ill = 1'b0;
    logic             m_berr = 1'b0;
    logic [6:0]       cur_op = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // What each instruction class asks of the datapath.
    function automatic info_t info(input logic [6:0] op);
        info_t f;
        f = '{valid: 1'b1, kind: K_WB, alu: 2'd0, imm: 1'b1, wb: 2'd0, wbpc: 2'd0};
        case (op)
            OP_R:   begin f.alu = 2'd2; f.imm = 1'b0; end
            OP_I:   f.alu = 2'd3;
            OP_LD:  begin f.kind = K_LOAD; f.wb = 2'd1; end
            OP_ST:  f.kind = K_STORE;
            OP_BR:  begin f.kind = K_BR; f.alu = 2'd1; f.imm = 1'b0; end
            OP_JAL: begin f.wb = 2'd2; f.wbpc = 2'd1; end
            OP_JR:  begin f.wb = 2'd2; f.wbpc = 2'd2; end
            OP_LUI: f.wb = 2'd3;
            default: f.valid = 1'b0;
        endcase
        return f;
    endfunction

    task automatic push(input cyc_t r_in, input logic rst);
        cyc_t r;
        r = r_in;
        r.rst = rst;
        r.opcode = cur_op;
        r.ill = m_ill;
        r.berr = m_berr;
        r.instret = m_instret;
        @(posedge clk);
        #1;
        reset = r.rst;
        opcode = r.opcode;
        branch_taken = r.br;
        imem_ready = r.iready;
        dmem_ready = r.dready;
        exp_q.push_back(r);
    endtask

    // iw/dw: wait cycles before ready (negative = ready never comes).
    // cut >= 0: abandon the instruction before that memory cycle.
    task automatic gen_instr(input logic [6:0] op, input int iw, input int dw,
                             input logic tk, input int cut, output int ncyc);
        info_t f;
        cyc_t  r;
        int    n;
        f = info(op);
        cur_op = op;
        ncyc = 0;
        n = (iw < 0) ? TMO + 1 : iw + 1;
        for (int k = 0; k < n; k++) begin
            r = '0; r.st = 3'd1; r.imem_req = 1'b1;
            r.iready = (iw >= 0) && (k == n - 1);
            r.ir_load = r.iready;
            push(r, 1'b0); ncyc++;
        end
        if (iw < 0) begin m_berr = 1'b1; return; end
        r = '0; r.st = 3'd2;
        push(r, 1'b0); ncyc++;
        if (!f.valid) begin m_ill = 1'b1; return; end
        r = '0; r.st = 3'd3; r.alu = f.alu; r.imm = f.imm;
        if (f.kind == K_BR) begin
            r.br = tk; r.pc_load = 1'b1; r.pc_src = tk ? 2'd1 : 2'd0;
            push(r, 1'b0); ncyc++;
            m_instret = m_instret + CNT_W'(1);
            return;
        end
        push(r, 1'b0); ncyc++;
        if (f.kind == K_LOAD || f.kind == K_STORE) begin
            n = (dw < 0) ? TMO + 1 : dw + 1;
            for (int k = 0; k < n; k++) begin
                if (cut >= 0 && k == cut) return;
                r = '0; r.st = 3'd4; r.dmem_req = 1'b1; r.imm = 1'b1;
                r.dmem_we = (f.kind == K_STORE);
                r.dready = (dw >= 0) && (k == n - 1);
                r.pc_load = r.dready && (f.kind == K_STORE);
                push(r, 1'b0); ncyc++;
            end
            if (dw < 0) begin m_berr = 1'b1; return; end
            if (f.kind == K_STORE) begin
                m_instret = m_instret + CNT_W'(1);
                return;
            end
        end
        r = '0; r.st = 3'd5; r.rwe = 1'b1; r.pc_load = 1'b1;
        r.wb = f.wb; r.pc_src = f.wbpc;
        push(r, 1'b0); ncyc++;
        m_instret = m_instret + CNT_W'(1);
    endtask

    task automatic gen_trap(input int n);
        cyc_t r;
        for (int k = 0; k < n; k++) begin
            r = '0; r.st = 3'd6;
            push(r, 1'b0);
        end
    endtask

    // Holds reset for n cycles, then one IDLE cycle after release.
    task automatic do_reset(input int n);
        cyc_t r;
        m_instret = '0; m_ill = 1'b0; m_berr = 1'b0; cur_op = '0;
        for (int k = 0; k < n; k++) begin
            r = '0;
            push(r, 1'b1);
        end
        r = '0;
        push(r, 1'b0);
    endtask

    // Per-cycle compare against the expected trace.
    initial begin
        cyc_t e;
        logic [17:0] act, expv;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                expv = {e.st, e.imem_req, e.ir_load, e.pc_load, e.pc_src, e.dmem_req,
                        e.dmem_we, e.alu, e.imm, e.rwe, e.wb, e.ill, e.berr};
                act  = {state_o, imem_req, ir_load, pc_load, pc_src, dmem_req,
                        dmem_we, alu_control, imm_enable, reg_write_enable, wb_sel,
                        illegal_instr, bus_error};
                check($sformatf("outputs@%0t", $time), 32'(act), 32'(expv));
                check($sformatf("instret@%0t", $time), 32'(instret_count), 32'(e.instret));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        do_reset(2);

        gen_instr(OP_R, 0, 0, 1'b0, -1, n);
        check("add_cycles", 32'(n), 32'd4);
        #2;
        check("add_wb_state", 32'(state_o), 32'd5);
        check("add_wb_rwe", 32'(reg_write_enable), 32'd1);
        check("add_wb_sel", 32'(wb_sel), 32'd0);

        gen_instr(OP_BR, 0, 0, 1'b1, -1, n);
        check("beq_t_cycles", 32'(n), 32'd3);
        #2;
        check("beq_t_pc_src", 32'(pc_src), 32'd1);
        check("beq_t_instret", 32'(instret_count), 32'd1);

        gen_instr(OP_BR, 0, 0, 1'b0, -1, n);
        check("beq_nt_cycles", 32'(n), 32'd3);
        #2;
        check("beq_nt_pc_src", 32'(pc_src), 32'd0);
        check("beq_nt_rwe", 32'(reg_write_enable), 32'd0);

        gen_instr(OP_LD, 0, 3, 1'b0, -1, n);
        check("lw_cycles", 32'(n), 32'd8);
        #2;
        check("lw_wb_sel", 32'(wb_sel), 32'd1);
        check("lw_instret", 32'(instret_count), 32'd3);

        gen_instr(OP_ST, 1, 0, 1'b0, -1, n);
        check("sw_cycles", 32'(n), 32'd5);
        gen_instr(OP_I, 0, 0, 1'b0, -1, n);
        gen_instr(OP_LUI, 0, 0, 1'b0, -1, n);
        #2;
        check("lui_wb_sel", 32'(wb_sel), 32'd3);
        gen_instr(OP_JAL, 0, 0, 1'b0, -1, n);
        gen_instr(OP_JR, 0, 0, 1'b0, -1, n);
        #2;
        check("jalr_pc_src", 32'(pc_src), 32'd2);

        // Ready on the fifth fetch cycle, same cycle as the limit.
        gen_instr(OP_R, TMO, 0, 1'b0, -1, n);
        check("late_ready_cycles", 32'(n), 32'd8);
        #2;
        check("late_ready_berr", 32'(bus_error), 32'd0);

        // Retire count wraps at 2^CNT_W.
        for (int k = 0; k < 8; k++) gen_instr(OP_I, 0, 0, 1'b0, -1, n);
        #2;
        check("wrap_instret", 32'(instret_count), 32'd1);

        do_reset(1);
        gen_instr(OP_BAD, 0, 0, 1'b0, -1, n);
        check("illegal_cycles", 32'(n), 32'd2);
        gen_trap(20);
        #2;
        check("illegal_state", 32'(state_o), 32'd6);
        check("illegal_flag", 32'(illegal_instr), 32'd1);

        do_reset(1);
        gen_instr(OP_R, -1, 0, 1'b0, -1, n);
        check("fetch_to_cycles", 32'(n), 32'd5);
        gen_trap(6);
        #2;
        check("fetch_to_berr", 32'(bus_error), 32'd1);

        do_reset(1);
        gen_instr(OP_LD, 0, -1, 1'b0, -1, n);
        gen_trap(4);
        #2;
        check("dmem_to_state", 32'(state_o), 32'd6);

        do_reset(1);
        gen_instr(OP_R, 0, 0, 1'b0, -1, n);
        gen_instr(OP_ST, 0, 5, 1'b0, 2, n);
        #2;
        check("sw_mid_dmem_req", 32'(dmem_req), 32'd1);
        do_reset(2);
        #2;
        check("rst_mid_state", 32'(state_o), 32'd0);
        check("rst_mid_instret", 32'(instret_count), 32'd0);
        check("rst_mid_dmem_we", 32'(dmem_we), 32'd0);
        gen_instr(OP_R, 0, 0, 1'b0, -1, n);

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
